spi_master_loader: RTL and testbench

- Fabric-side single-lane SPI master that drives the PULPino SPI slave loader port (spi_clk/spi_cs/spi_sdi0, reads spi_sdo0).
- Converts word-level write/read commands into SPI memory-access frames: write opcode 0x02 and read opcode 0x0B.
- Uses SPI mode 0, MSB first.
- Lets the emulation top or a boot FSM preload and check PULPino memory without the PS SPI controller.

---
 rtl/spi_master_loader_if.sv | 30 +++
 rtl/spi_master_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_master_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_loader_if.sv
// Command, write-data, read-data and status bundle for spi_master_loader.
// Signals carry DUT-relative suffixes: _i is driven into the loader, _o comes out of it.
// Modports: slave = loader side, master = the agent issuing commands (boot FSM, bench).
interface spi_master_loader_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        rdata_ready_i;
  logic        busy_o;
  logic        done_o;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
    input  wdata_i, wdata_valid_i, rdata_ready_i,
    output cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
    output wdata_i, wdata_valid_i, rdata_ready_i,
    input  cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/spi_master_loader.sv
// Single-lane SPI mode-0 master turning word write/read commands into PULPino loader frames (0x02 / 0x0B).
// Latency: CLK_DIV setup + 2*CLK_DIV per SCK bit + CLK_DIV hold + CLK_DIV gap; done_o in the last gap cycle.
// Backpressure: write words and read-word hand-off stall with SCK parked low; commands accepted only in IDLE.
// Ports: clk/rst_n; bus (slave modport: cmd_*, wdata_*, rdata_*, busy_o, done_o); spi_sck_o/spi_cs_o/spi_mosi_o/spi_miso_i.
module spi_master_loader #(
  parameter int CLK_DIV      = 4,   // SCK half-period in clk cycles, 1..255
  parameter int DUMMY_CYCLES = 32   // SCK cycles between address and read data
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_loader_if.slave   bus,
  output logic                 spi_sck_o,
  output logic                 spi_cs_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i
);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, WLOAD, WDATA, RDATA, RWAIT, CS_HOLD, GAP
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_CYCLES - 1);
  localparam logic [7:0]  OP_WRITE   = 8'h02;
  localparam logic [7:0]  OP_READ    = 8'h0B;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;      // position inside the current half-period
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [31:0] sh_q, sh_d;        // remaining transmit bits, MSB next
  logic [31:0] rx_q, rx_d;        // receive shifter
  logic [15:0] bit_q, bit_d;      // bits left in the current segment minus one
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0]  word_q, word_d;    // data words still to transfer
  logic [31:0] rdata_q, rdata_d;
  logic        rvld_q, rvld_d;
  logic        pend_q, pend_d;    // completed read word parked in rx_q, output slot busy

  logic        div_end;
  logic        slot_free;
  logic [31:0] rx_word;
  logic [8:0]  word_left;
  logic [7:0]  opcode;

  assign div_end   = (div_q == DIV_LAST);
  // The output register can take a word if empty or being emptied this cycle.
  assign slot_free = !rvld_q || bus.rdata_ready_i;
  assign rx_word   = {rx_q[30:0], spi_miso_i};
  assign word_left = word_q - 9'd1;
  assign opcode    = write_q ? OP_WRITE : OP_READ;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    write_d = write_q;
    addr_d  = addr_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    rvld_d  = rvld_q;
    pend_d  = pend_q;

    if (rvld_q && bus.rdata_ready_i) begin
      rvld_d = 1'b0;
    end
    // A parked word moves to the output as soon as the slot frees up.
    if (pend_q && slot_free) begin
      rdata_d = rx_q;
      rvld_d  = 1'b1;
      pend_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        div_d  = '0;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (bus.cmd_valid_i) begin
          write_d = bus.cmd_write_i;
          addr_d  = bus.cmd_addr_i;
          word_d  = {1'b0, bus.cmd_len_i} + 9'd1;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = '0;
          state_d = CMD;
          mosi_d  = opcode[7];
          sh_d    = {opcode[6:0], 25'b0};
          bit_d   = 16'd7;
        end
      end

      CMD, ADDR, DUMMY, WDATA, RDATA: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end && !sck_q) begin
          // Rising edge: sample MISO on the same clk edge that raises SCK.
          sck_d = 1'b1;
          if (state_q == RDATA) begin
            rx_d = rx_word;
            if (bit_q == 16'd0) begin
              if (slot_free) begin
                rdata_d = rx_word;
                rvld_d  = 1'b1;
              end else begin
                pend_d = 1'b1;
              end
            end
          end
        end else if (div_end) begin
          // End of high phase: the next low phase starts with fresh MOSI.
          sck_d = 1'b0;
          if (bit_q != 16'd0) begin
            bit_d  = bit_q - 16'd1;
            mosi_d = sh_q[31];
            sh_d   = {sh_q[30:0], 1'b0};
          end else begin
            mosi_d = 1'b0;
            sh_d   = '0;
            bit_d  = 16'd31;
            case (state_q)
              CMD: begin
                state_d = ADDR;
                mosi_d  = addr_q[31];
                sh_d    = {addr_q[30:0], 1'b0};
              end
              ADDR: begin
                if (write_q) begin
                  state_d = WLOAD;
                end else if (DUMMY_CYCLES > 0) begin
                  state_d = DUMMY;
                  bit_d   = DUMMY_LAST;
                end else begin
                  state_d = RDATA;
                end
              end
              DUMMY: state_d = RDATA;
              WDATA: begin
                word_d  = word_left;
                state_d = (word_left != 9'd0) ? WLOAD : CS_HOLD;
              end
              RDATA: begin
                word_d = word_left;
                if (pend_q && !slot_free) begin
                  state_d = RWAIT;
                end else if (word_left != 9'd0) begin
                  state_d = RDATA;
                end else begin
                  state_d = CS_HOLD;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end

      WLOAD: begin
        if (bus.wdata_valid_i) begin
          state_d = WDATA;
          mosi_d  = bus.wdata_i[31];
          sh_d    = {bus.wdata_i[30:0], 1'b0};
          bit_d   = 16'd31;
          div_d   = '0;
        end
      end

      RWAIT: begin
        // The parked word leaves this cycle via the hand-off logic above.
        if (slot_free) begin
          state_d = (word_q != 9'd0) ? RDATA : CS_HOLD;
        end
      end

      CS_HOLD: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      pend_q  <= pend_d;
    end
  end

  assign spi_sck_o         = sck_q;
  assign spi_mosi_o        = mosi_q;
  assign spi_cs_o          = (state_q == IDLE) || (state_q == GAP);
  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.wdata_ready_o = (state_q == WLOAD);
  assign bus.rdata_o       = rdata_q;
  assign bus.rdata_valid_o = rvld_q;
  assign bus.done_o        = (state_q == GAP) && div_end;

endmodule

// File: tb/tb_spi_master_loader.sv
// Self-checking bench for spi_master_loader: frame table plus reset and back-to-back sequences.
// A slave model on the SPI pins assembles MOSI and serves MISO; scoreboard queues hold expectations.
// Inputs change 1 time unit after the rising clk edge; outputs are sampled on the falling edge.
module tb_spi_master_loader;
  localparam int CLK_DIV = 2;
  localparam int DUMMY   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_loader_if bus();
  logic sck, cs, mosi;
  logic miso = 1'b0;

  spi_master_loader #(.CLK_DIV(CLK_DIV), .DUMMY_CYCLES(DUMMY)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .spi_sck_o(sck), .spi_cs_o(cs), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );

  typedef struct {
    logic             wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [3:0][31:0] w;       // w[0] is the first word
    int               wstall;  // cycles word 1 is withheld
    int               rstall;  // cycles rdata_ready_i stays low after word 0 appears
    int               edges;   // expected SCK rising edges in the frame
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0]      exp_mosi[$];
  logic [31:0]      exp_rdata[$];
  int               exp_edges[$];
  logic [3:0][31:0] slv_rd;

  int          edge_cnt = 0;
  int          bad_edges = 0;
  int          done_cnt = 0;
  int          cs_high_cnt = 0;
  int          gap_len = 0;
  logic [31:0] mosi_sh = '0;
  logic [31:0] mon_e;
  logic        sck_prev = 1'b0;
  logic        cs_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  function automatic logic slave_bit(input int n);
    int k;
    k = n - (40 + DUMMY);
    if (k < 0 || k >= 128) return 1'b0;
    return slv_rd[k / 32][31 - (k % 32)];
  endfunction

  // SPI slave model and output scoreboard.
  always @(negedge clk) begin
    if (bus.done_o) begin
      done_cnt++;
      if (exp_edges.size() == 0) fail_now("unexpected_done");
      else check("frame_edges", edge_cnt, exp_edges.pop_front());
    end
    if (!rst_n) begin
      sck_prev    = 1'b0;
      cs_prev     = 1'b1;
      cs_high_cnt = 0;
    end else begin
      if (cs_prev && !cs) begin
        edge_cnt = 0;
        gap_len  = cs_high_cnt;
      end
      if (cs) cs_high_cnt++;
      else cs_high_cnt = 0;
      if (sck && !sck_prev) begin
        if (cs) bad_edges++;
        mosi_sh = {mosi_sh[30:0], mosi};
        edge_cnt++;
        if (edge_cnt == 8 || (edge_cnt >= 40 && (edge_cnt - 8) % 32 == 0)) begin
          if (exp_mosi.size() == 0) fail_now("mosi_extra_word");
          else begin
            mon_e = exp_mosi.pop_front();
            if (edge_cnt == 8) check("mosi_opcode", {24'b0, mosi_sh[7:0]}, mon_e);
            else check("mosi_word", mosi_sh, mon_e);
          end
        end
      end
      if (!sck && (sck_prev || (cs_prev && !cs))) miso = slave_bit(edge_cnt);
      if (bus.rdata_valid_o && bus.rdata_ready_i) begin
        if (exp_rdata.size() == 0) fail_now("rdata_extra_word");
        else check("rdata_word", bus.rdata_o, exp_rdata.pop_front());
      end
      sck_prev = sck;
      cs_prev  = cs;
    end
  end

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bit got = 0;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_len_i   = len;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin got = 1; break; end
    end
    if (!got) fail_now("cmd_accept_timeout");
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic feed_words(input logic [3:0][31:0] w, input int n, input int stall);
    bit got;
    int e0, bad;
    for (int i = 0; i < n; i++) begin
      got = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (bus.wdata_ready_o) begin got = 1; break; end
      end
      if (!got) begin fail_now("wdata_ready_timeout"); return; end
      if (i == 1 && stall > 0) begin
        e0 = edge_cnt;
        bad = 0;
        for (int c = 0; c < stall; c++) begin
          @(negedge clk);
          if (sck || cs) bad++;
        end
        check("wstall_sck_low_cs_low", bad, 0);
        check("wstall_no_edges", edge_cnt, e0);
        check("wstall_ready_held", 32'(bus.wdata_ready_o), 1);
      end
      @(posedge clk); #1;
      bus.wdata_valid_i = 1'b1;
      bus.wdata_i       = w[i];
      @(posedge clk); #1;
      bus.wdata_valid_i = 1'b0;
    end
  endtask

  task automatic read_stall(input logic [31:0] w0, input int stall);
    bit got = 0;
    int e0 = 0, bad_hold = 0, bad_sck = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.rdata_valid_o) begin got = 1; break; end
    end
    if (!got) begin fail_now("rdata_valid_timeout"); bus.rdata_ready_i = 1'b1; return; end
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      if (bus.rdata_o !== w0 || !bus.rdata_valid_o) bad_hold++;
      if (c == stall - 100) e0 = edge_cnt;
      if (c >= stall - 100 && sck) bad_sck++;
    end
    check("rstall_rdata_held", bad_hold, 0);
    check("rstall_sck_low", bad_sck, 0);
    check("rstall_no_edges", edge_cnt, e0);
    check("rstall_cs_low", 32'(cs), 0);
    @(posedge clk); #1;
    bus.rdata_ready_i = 1'b1;
  endtask

  task automatic wait_done(input int d0, input string tag);
    bit got = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done_cnt != d0) begin got = 1; break; end
    end
    if (!got) fail_now({tag, "_done_timeout"});
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int d0, n;
    @(posedge clk); #1;
    n = int'(v.len) + 1;
    exp_mosi.push_back(v.wr ? 32'h02 : 32'h0B);
    exp_mosi.push_back(v.addr);
    if (v.wr) begin
      for (int i = 0; i < n; i++) exp_mosi.push_back(v.w[i]);
    end else begin
      for (int i = 0; i < DUMMY / 32 + n; i++) exp_mosi.push_back(32'h0);
      for (int i = 0; i < n; i++) exp_rdata.push_back(v.w[i]);
    end
    exp_edges.push_back(v.edges);
    slv_rd    = v.w;
    d0        = done_cnt;
    bad_edges = 0;
    if (!v.wr && v.rstall > 0) bus.rdata_ready_i = 1'b0;
    issue_cmd(v.wr, v.addr, v.len);
    check({tag, "_busy"}, 32'(bus.busy_o), 1);
    fork
      begin if (v.wr) feed_words(v.w, n, v.wstall); end
      begin if (!v.wr && v.rstall > 0) read_stall(v.w[0], v.rstall); end
    join
    wait_done(d0, tag);
    repeat (3) @(negedge clk);
    check({tag, "_one_done"}, done_cnt - d0, 1);
    check({tag, "_ready_after"}, 32'(bus.cmd_ready_o), 1);
    check({tag, "_idle_cs"}, 32'(cs), 1);
    check({tag, "_sck_only_with_cs"}, bad_edges, 0);
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 32'h0010_0000, len: 8'd0,
                w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, wstall: 0, rstall: 0, edges: 72};
    vecs[1] = '{wr: 1'b0, addr: 32'h0010_0000, len: 8'd1,
                w: {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, wstall: 0, rstall: 0, edges: 136};
    vecs[2] = '{wr: 1'b1, addr: 32'h0010_0040, len: 8'd2,
                w: {32'h0, 32'h80000001, 32'h0123CAFE, 32'hA5A5F00F}, wstall: 20, rstall: 0, edges: 136};
    vecs[3] = '{wr: 1'b0, addr: 32'h0010_0000, len: 8'd1,
                w: {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, wstall: 0, rstall: 300, edges: 136};
    vecs[4] = '{wr: 1'b0, addr: 32'hFFFF_FFFC, len: 8'd0,
                w: {32'h0, 32'h0, 32'h0, 32'h80000001}, wstall: 0, rstall: 0, edges: 104};
    vecs[5] = '{wr: 1'b1, addr: 32'h0000_0000, len: 8'd3,
                w: {32'hFFFFFFFF, 32'h00000000, 32'h55AA55AA, 32'hC0FFEE11}, wstall: 0, rstall: 0, edges: 168};
    post    = '{wr: 1'b1, addr: 32'h0010_0100, len: 8'd0,
                w: {32'h0, 32'h0, 32'h0, 32'h5A5AA5A5}, wstall: 0, rstall: 0, edges: 72};

    bus.cmd_valid_i   = 1'b0;
    bus.cmd_write_i   = 1'b0;
    bus.cmd_addr_i    = '0;
    bus.cmd_len_i     = '0;
    bus.wdata_i       = '0;
    bus.wdata_valid_i = 1'b0;
    bus.rdata_ready_i = 1'b1;
    slv_rd            = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 1);
    check("rst_sck", 32'(sck), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 1);
    check("rst_wdata_ready", 32'(bus.wdata_ready_o), 0);
    check("rst_rdata_valid", 32'(bus.rdata_valid_o), 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second command held valid while the first frame runs.
    begin
      int d0;
      bit got = 0;
      logic [3:0][31:0] wa, wb;
      wa = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};
      wb = {32'h0, 32'h0, 32'h0, 32'hCAFEBABE};
      exp_mosi.push_back(32'h02); exp_mosi.push_back(32'h0000_0200); exp_mosi.push_back(wa[0]);
      exp_mosi.push_back(32'h02); exp_mosi.push_back(32'h0000_0300); exp_mosi.push_back(wb[0]);
      exp_edges.push_back(72);
      exp_edges.push_back(72);
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b1;
      bus.cmd_addr_i  = 32'h0000_0200;
      bus.cmd_len_i   = 8'd0;
      @(negedge clk);
      check("b2b_first_ready", 32'(bus.cmd_ready_o), 1);
      @(posedge clk); #1;
      bus.cmd_addr_i = 32'h0000_0300;
      fork
        begin
          feed_words(wa, 1, 0);
          feed_words(wb, 1, 0);
        end
        begin
          for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) begin got = 1; break; end
          end
          if (!got) fail_now("b2b_second_accept_timeout");
          else check("b2b_accept_after_done", done_cnt - d0, 1);
          @(posedge clk); #1;
          bus.cmd_valid_i = 1'b0;
        end
      join
      wait_done(d0 + 1, "b2b");
      repeat (3) @(negedge clk);
      check("b2b_two_dones", done_cnt - d0, 2);
      check("b2b_cs_gap_ge_div", 32'(gap_len >= CLK_DIV), 1);
    end

    // Reset asserted in the middle of the address phase.
    begin
      int d0;
      bit got = 0;
      exp_mosi.push_back(32'h0B);
      exp_mosi.push_back(32'h0010_0000);
      issue_cmd(1'b0, 32'h0010_0000, 8'd0);
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (edge_cnt >= 18) begin got = 1; break; end
      end
      if (!got) fail_now("mid_addr_timeout");
      repeat (CLK_DIV) @(negedge clk);
      d0 = done_cnt;
      check("mid_addr_cs_low", 32'(cs), 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cs", 32'(cs), 1);
      check("arst_sck", 32'(sck), 0);
      check("arst_busy", 32'(bus.busy_o), 0);
      check("arst_cmd_ready", 32'(bus.cmd_ready_o), 1);
      exp_mosi.delete();
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_ready_after", 32'(bus.cmd_ready_o), 1);
      check("arst_cs_idle", 32'(cs), 1);
      run_frame(post, "post_rst");
    end

    check("scoreboard_drained", exp_mosi.size() + exp_rdata.size() + exp_edges.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
